// File: rtl/snake_gfx_pkg.sv
// Shared graphics definitions: colour format, framebuffer geometry and the
// sprite blitter state encoding.
package snake_gfx_pkg;

   localparam int                RGB_W           = 12;
   localparam logic [RGB_W-1:0]  TRANSPARENT_RGB = 12'hF0F;

   localparam int FB_W  = 160;
   localparam int FB_H  = 120;
   localparam int FB_AW = $clog2(FB_W * FB_H);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } blit_state_t;

endpackage

// File: rtl/sprite_blitter_if.sv
// Sprite ROM read port plus framebuffer write port. The blitter is the master:
// it drives ROM coordinates and write requests, and receives pixel data and
// write acceptance.
interface sprite_blitter_if
   import snake_gfx_pkg::*;
#(
   parameter int SPRITE_W = 16,
   parameter int SPRITE_H = 16,
   parameter int AW       = FB_AW
);

   logic [$clog2(SPRITE_W)-1:0] rom_sx;
   logic [$clog2(SPRITE_H)-1:0] rom_sy;
   logic [RGB_W-1:0]            rom_rgb;

   logic                        fb_we;
   logic [AW-1:0]               fb_addr;
   logic [RGB_W-1:0]            fb_wdata;
   logic                        fb_ready;

   modport master (
      output rom_sx, rom_sy, fb_we, fb_addr, fb_wdata,
      input  rom_rgb, fb_ready
   );

   modport slave (
      input  rom_sx, rom_sy, fb_we, fb_addr, fb_wdata,
      output rom_rgb, fb_ready
   );

endinterface

// File: rtl/sprite_blitter.sv
// Copies a SPRITE_W x SPRITE_H sprite from a combinational ROM into the
// framebuffer at (dst_x, dst_y), skipping the colour key and clipping pixels
// that land off-screen. One pixel per cycle while the write port keeps up.
module sprite_blitter
   import snake_gfx_pkg::*;
#(
   parameter int               SPRITE_W    = 16,
   parameter int               SPRITE_H    = 16,
   parameter int               FB_W        = snake_gfx_pkg::FB_W,
   parameter int               FB_H        = snake_gfx_pkg::FB_H,
   parameter logic [RGB_W-1:0] TRANSPARENT = TRANSPARENT_RGB
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   input  logic [$clog2(FB_W)-1:0]   dst_x,
   input  logic [$clog2(FB_H)-1:0]   dst_y,
   output logic                      busy,
   output logic                      done,
   sprite_blitter_if.master          bus
);

   localparam int XW  = $clog2(FB_W);
   localparam int YW  = $clog2(FB_H);
   localparam int SXW = $clog2(SPRITE_W);
   localparam int SYW = $clog2(SPRITE_H);
   localparam int AW  = $clog2(FB_W * FB_H);

   blit_state_t       state_q, state_d;

   logic [SXW-1:0]    sx_q;
   logic [SYW-1:0]    sy_q;
   logic [XW-1:0]     dx_q;
   logic [YW-1:0]     dy_q;

   logic [XW:0]       x_sum;
   logic [YW:0]       y_sum;
   logic              in_bounds;
   logic              adv;
   logic              last_px;

   logic              fb_we_q;
   logic [AW-1:0]     fb_addr_q;
   logic [RGB_W-1:0]  fb_wdata_q;
   logic [SXW-1:0]    rom_sx_c;
   logic [SYW-1:0]    rom_sy_c;

   // One extra bit on each sum so a sprite hanging off the right/bottom edge
   // compares as out of range instead of wrapping back on-screen.
   assign x_sum     = {1'b0, dx_q} + (XW+1)'(sx_q);
   assign y_sum     = {1'b0, dy_q} + (YW+1)'(sy_q);
   assign in_bounds = (x_sum < (XW+1)'(FB_W)) && (y_sum < (YW+1)'(FB_H));

   // The output stage may take a new pixel when it is empty or being accepted.
   assign adv     = !fb_we_q || bus.fb_ready;
   assign last_px = (sx_q == SXW'(SPRITE_W - 1)) && (sy_q == SYW'(SPRITE_H - 1));

   // State register with synchronous reset.
   always_ff @(posedge clk) begin
      // NOTE: clocked state is always assigned with <= so every flop samples pre-edge values.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic.
   always_comb begin
      // NOTE: default assignment first, so no path through the case leaves state_d unassigned (no latch).
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)          state_d = RUN;
         RUN:     if (adv && last_px) state_d = DRAIN;
         DRAIN:   if (adv)            state_d = DONE;
         DONE:                        state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Status outputs and ROM address; the ROM sees the counters only while scanning.
   always_comb begin
      busy     = (state_q == RUN) || (state_q == DRAIN);
      done     = (state_q == DONE);
      rom_sx_c = '0;
      rom_sy_c = '0;
      if (state_q == RUN) begin
         rom_sx_c = sx_q;
         rom_sy_c = sy_q;
      end
   end

   // Scan counters, latched destination and the registered write stage.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sx_q       <= '0;
         sy_q       <= '0;
         dx_q       <= '0;
         dy_q       <= '0;
         fb_we_q    <= 1'b0;
         fb_addr_q  <= '0;
         fb_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  dx_q <= dst_x;
                  dy_q <= dst_y;
                  sx_q <= '0;
                  sy_q <= '0;
               end
            end
            RUN: begin
               if (adv) begin
                  fb_addr_q  <= AW'(y_sum) * AW'(FB_W) + AW'(x_sum);
                  fb_wdata_q <= bus.rom_rgb;
                  fb_we_q    <= (bus.rom_rgb != TRANSPARENT) && in_bounds;
                  sx_q       <= sx_q + 1'b1;
                  if (sx_q == SXW'(SPRITE_W - 1)) sy_q <= sy_q + 1'b1;
               end
            end
            DRAIN: begin
               if (adv) fb_we_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.rom_sx   = rom_sx_c;
   assign bus.rom_sy   = rom_sy_c;
   assign bus.fb_we    = fb_we_q;
   assign bus.fb_addr  = fb_addr_q;
   assign bus.fb_wdata = fb_wdata_q;

endmodule
